// File: rtl/uart_row_parser.sv
// uart_row_parser: decodes {Y lo, Y hi, 240 pixel bytes, stop} row packets into frame-buffer byte writes and answer bytes.
// Latency: rx_done in cycle t -> fb_we / row_done in t+1; tx_start in t+1 at the earliest.
// Backpressure: single pending answer slot; a newer answer overwrites an unsent one and sets sticky ans_ovf.
// Optional feature macro: PARSER_TIMEOUT_EN (inter-byte gap timeout, aborts the packet with 0x11).
module uart_row_parser #(
  parameter int         BYTE_SIZE_ROW         = 240,
  parameter int         HEIGHT                = 480,
  parameter logic [7:0] STOP_BYTE             = 8'hDD,
  parameter logic [7:0] ANSWER_CODE_TAKE_ROW  = 8'hCC,
  parameter logic [7:0] ANSWER_CODE           = 8'hAA,
  parameter logic [7:0] SUCCESSFULLY_RECEIVED = 8'hFF,
  parameter logic [7:0] NOT_ALL_RECEIVED      = 8'h11,
  parameter int         TIMEOUT_CYCLES        = 500_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        fb_we,
  output logic [16:0] fb_addr,
  output logic [7:0]  fb_wdata,
  output logic        row_done,
  output logic [8:0]  row_y,
  output logic        ans_ovf
);

  typedef enum logic [1:0] {Y_LO, Y_HI, DATA, STOP} state_t;

  localparam logic [9:0] HEIGHT_W   = 10'(HEIGHT);
  localparam logic [7:0] LAST_IDX   = 8'(BYTE_SIZE_ROW - 1);

  state_t      state_q, state_d;
  logic [7:0]  y_lo_q, y_lo_d;
  logic [8:0]  y_q, y_d;
  logic        row_bad_q, row_bad_d;
  logic [16:0] base_q, base_d;
  logic [7:0]  idx_q, idx_d;

  logic        fb_we_q, fb_we_d;
  logic [16:0] fb_addr_q, fb_addr_d;
  logic [7:0]  fb_wdata_q, fb_wdata_d;
  logic        row_done_q, row_done_d;

  logic        pend_vld_q, pend_vld_d;
  logic [7:0]  pend_dat_q, pend_dat_d;
  logic        tx_start_q, tx_start_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        ans_ovf_q, ans_ovf_d;

  // Answer request produced by the FSM output logic for this cycle.
  logic        ans_req;
  logic [7:0]  ans_code;
  logic [8:0]  y_full;
  logic [16:0] y_ext;
  logic        can_launch;
  logic        timeout;

  assign y_full = {rx_data[0], y_lo_q};
  assign y_ext  = {8'b0, y_full};

`ifdef PARSER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] gap_q, gap_d;

  // Gap counter: idle in Y_LO, restarts on every received byte.
  always_comb begin
    gap_d = gap_q + 1'b1;
    if (state_q == Y_LO || rx_done || timeout) begin
      gap_d = '0;
    end
  end

  assign timeout = (state_q != Y_LO) && !rx_done && (gap_q == GAP_LAST);

  // Gap counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_q <= '0;
    end else begin
      gap_q <= gap_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= Y_LO;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: advances only on a received byte, or falls back on timeout.
  always_comb begin
    state_d = state_q;
    if (rx_done) begin
      case (state_q)
        Y_LO:    state_d = Y_HI;
        Y_HI:    state_d = DATA;
        DATA:    state_d = (idx_q == LAST_IDX) ? STOP : DATA;
        STOP:    state_d = Y_LO;
        default: state_d = Y_LO;
      endcase
    end else if (timeout) begin
      state_d = Y_LO;
    end
  end

  // FSM outputs: row bookkeeping, frame-buffer write and the answer to queue.
  always_comb begin
    y_lo_d     = y_lo_q;
    y_d        = y_q;
    row_bad_d  = row_bad_q;
    base_d     = base_q;
    idx_d      = idx_q;
    fb_we_d    = 1'b0;
    fb_addr_d  = fb_addr_q;
    fb_wdata_d = fb_wdata_q;
    row_done_d = 1'b0;
    ans_req    = 1'b0;
    ans_code   = 8'h00;
    if (rx_done) begin
      case (state_q)
        Y_LO: begin
          y_lo_d   = rx_data;
          ans_req  = 1'b1;
          ans_code = ANSWER_CODE_TAKE_ROW;
        end
        Y_HI: begin
          y_d       = y_full;
          row_bad_d = ({1'b0, y_full} >= HEIGHT_W);
          // y*240 as a shift-subtract; never wraps for y < 512.
          base_d    = (y_ext << 8) - (y_ext << 4);
          idx_d     = 8'h00;
          ans_req   = 1'b1;
          ans_code  = ANSWER_CODE_TAKE_ROW;
        end
        DATA: begin
          if (!row_bad_q) begin
            fb_we_d    = 1'b1;
            fb_addr_d  = base_q + {9'b0, idx_q};
            fb_wdata_d = rx_data;
          end
          idx_d    = idx_q + 8'd1;
          ans_req  = 1'b1;
          ans_code = ANSWER_CODE;
        end
        STOP: begin
          ans_req = 1'b1;
          idx_d   = 8'h00;
          if (rx_data == STOP_BYTE && !row_bad_q) begin
            ans_code   = SUCCESSFULLY_RECEIVED;
            row_done_d = 1'b1;
          end else begin
            ans_code = NOT_ALL_RECEIVED;
          end
        end
        default: ;
      endcase
    end else if (timeout) begin
      idx_d    = 8'h00;
      ans_req  = 1'b1;
      ans_code = NOT_ALL_RECEIVED;
    end
  end

  // Answer slot: launch the pending byte first; an empty slot lets a new answer go straight out.
  always_comb begin
    can_launch = !tx_busy && !tx_start_q;
    pend_vld_d = pend_vld_q;
    pend_dat_d = pend_dat_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    ans_ovf_d  = ans_ovf_q;
    if (pend_vld_q && can_launch) begin
      tx_start_d = 1'b1;
      tx_data_d  = pend_dat_q;
      pend_vld_d = ans_req;
      if (ans_req) begin
        pend_dat_d = ans_code;
      end
    end else if (ans_req) begin
      if (!pend_vld_q && can_launch) begin
        tx_start_d = 1'b1;
        tx_data_d  = ans_code;
      end else begin
        pend_vld_d = 1'b1;
        pend_dat_d = ans_code;
        if (pend_vld_q) begin
          ans_ovf_d = 1'b1;
        end
      end
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_lo_q     <= 8'h00;
      y_q        <= 9'h000;
      row_bad_q  <= 1'b0;
      base_q     <= 17'h0;
      idx_q      <= 8'h00;
      fb_we_q    <= 1'b0;
      fb_addr_q  <= 17'h0;
      fb_wdata_q <= 8'h00;
      row_done_q <= 1'b0;
      pend_vld_q <= 1'b0;
      pend_dat_q <= 8'h00;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      ans_ovf_q  <= 1'b0;
    end else begin
      y_lo_q     <= y_lo_d;
      y_q        <= y_d;
      row_bad_q  <= row_bad_d;
      base_q     <= base_d;
      idx_q      <= idx_d;
      fb_we_q    <= fb_we_d;
      fb_addr_q  <= fb_addr_d;
      fb_wdata_q <= fb_wdata_d;
      row_done_q <= row_done_d;
      pend_vld_q <= pend_vld_d;
      pend_dat_q <= pend_dat_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      ans_ovf_q  <= ans_ovf_d;
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign fb_we    = fb_we_q;
  assign fb_addr  = fb_addr_q;
  assign fb_wdata = fb_wdata_q;
  assign row_done = row_done_q;
  assign row_y    = y_q;
  assign ans_ovf  = ans_ovf_q;

endmodule

// File: tb/tb_uart_row_parser.sv
// Scoreboard bench for uart_row_parser: expected answers, writes and row completions are queued
// as bytes are sent and popped when the DUT produces them. Build with +define+PARSER_TIMEOUT_EN
// to also exercise the gap timeout (TIMEOUT_CYCLES = 1000).
module tb_uart_row_parser;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        fb_we;
  logic [16:0] fb_addr;
  logic [7:0]  fb_wdata;
  logic        row_done;
  logic [8:0]  row_y;
  logic        ans_ovf;

  logic        busy_model;
  logic        busy_force;
  assign tx_busy = busy_model | busy_force;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]  ans_q[$];
  int          wa_q[$];
  logic [7:0]  wd_q[$];
  int          row_q[$];

  uart_row_parser #(.TIMEOUT_CYCLES(1000)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_done(rx_done), .tx_busy(tx_busy),
    .tx_start(tx_start), .tx_data(tx_data), .fb_we(fb_we), .fb_addr(fb_addr),
    .fb_wdata(fb_wdata), .row_done(row_done), .row_y(row_y), .ans_ovf(ans_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Transmitter model: busy for 8 cycles after each start.
  initial begin
    busy_model = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (tx_start) begin
        busy_model = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        busy_model = 1'b0;
      end
    end
  end

  // Output monitor: every strobe must match the head of its expectation queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_start) begin
        if (ans_q.size() == 0) chk("tx_start_unexp", 32'(tx_start), 32'd0);
        else chk("tx_data", 32'(tx_data), 32'(ans_q.pop_front()));
      end
      if (fb_we) begin
        if (wa_q.size() == 0) chk("fb_we_unexp", 32'(fb_we), 32'd0);
        else begin
          chk("fb_addr", 32'(fb_addr), 32'(wa_q.pop_front()));
          chk("fb_wdata", 32'(fb_wdata), 32'(wd_q.pop_front()));
        end
      end
      if (row_done) begin
        if (row_q.size() == 0) chk("row_done_unexp", 32'(row_done), 32'd0);
        else chk("row_y", 32'(row_y), 32'(row_q.pop_front()));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_pkt(input logic [7:0] lo, input logic [7:0] hi, input logic [7:0] stop_b);
    logic [8:0] y;
    logic       bad;
    logic [7:0] d;
    y   = {hi[0], lo};
    bad = (y >= 9'd480);
    ans_q.push_back(8'hCC); send_byte(lo, 12);
    ans_q.push_back(8'hCC); send_byte(hi, 12);
    for (int i = 0; i < 240; i++) begin
      d = 8'($urandom);
      ans_q.push_back(8'hAA);
      if (!bad) begin
        wa_q.push_back(int'(y) * 240 + i);
        wd_q.push_back(d);
      end
      send_byte(d, 12);
    end
    if (stop_b == 8'hDD && !bad) begin
      ans_q.push_back(8'hFF);
      row_q.push_back(int'(y));
    end else begin
      ans_q.push_back(8'h11);
    end
    send_byte(stop_b, 20);
  endtask

  task automatic chk_reset_outputs(input string phase);
    chk({phase, "_tx_start"}, 32'(tx_start), 32'd0);
    chk({phase, "_tx_data"},  32'(tx_data),  32'd0);
    chk({phase, "_fb_we"},    32'(fb_we),    32'd0);
    chk({phase, "_fb_addr"},  32'(fb_addr),  32'd0);
    chk({phase, "_fb_wdata"}, 32'(fb_wdata), 32'd0);
    chk({phase, "_row_done"}, 32'(row_done), 32'd0);
    chk({phase, "_row_y"},    32'(row_y),    32'd0);
    chk({phase, "_ans_ovf"},  32'(ans_ovf),  32'd0);
  endtask

  // Hard stop in case the run wedges.
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, ans_q=%0d wa_q=%0d", ans_q.size(), wa_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    int n;
    rst_n      = 1'b0;
    rx_data    = 8'h00;
    rx_done    = 1'b0;
    busy_force = 1'b0;
    #1;
    chk_reset_outputs("rst0");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Good row 16 (hi byte bit0 = 0), bad stop byte, out-of-range row 480.
    send_pkt(8'h10, 8'h22, 8'hDD);
    send_pkt(8'h10, 8'h22, 8'h00);
    send_pkt(8'hE0, 8'h01, 8'hDD);
    repeat (20) @(negedge clk);

`ifdef PARSER_TIMEOUT_EN
    // Y plus 10 data bytes, then silence: abort answer about 1000 cycles later.
    ans_q.push_back(8'hCC); send_byte(8'h03, 12);
    ans_q.push_back(8'hCC); send_byte(8'h00, 12);
    for (int i = 0; i < 10; i++) begin
      d = 8'($urandom);
      ans_q.push_back(8'hAA);
      wa_q.push_back(720 + i);
      wd_q.push_back(d);
      send_byte(d, (i == 9) ? 0 : 12);
    end
    ans_q.push_back(8'h11);
    n = 0;
    while (n < 1500 && !(tx_start && tx_data == 8'h11)) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_latency_ok", 32'((n >= 990 && n <= 1010) ? 1 : 0), 32'd1);
    repeat (20) @(negedge clk);
    send_pkt(8'h00, 8'h00, 8'hDD);
    repeat (20) @(negedge clk);
`endif

    // Three answers while the transmitter is held busy: only the last survives.
    busy_force = 1'b1;
    wa_q.push_back(1200);
    send_byte(8'h05, 12);
    send_byte(8'h00, 12);
    d = 8'h5A;
    wd_q.push_back(d);
    send_byte(d, 12);
    chk("ans_ovf_set", 32'(ans_ovf), 32'd1);
    chk("tx_start_while_busy", 32'(tx_start), 32'd0);
    ans_q.push_back(8'hAA);
    busy_force = 1'b0;
    n = 0;
    while (n < 50 && ans_q.size() != 0) begin
      @(negedge clk);
      n++;
    end
    chk("ovf_drained", 32'(ans_q.size()), 32'd0);
    chk("ans_ovf_sticky", 32'(ans_ovf), 32'd1);

    // Continue to 100 data bytes, then reset mid-row.
    for (int i = 1; i < 100; i++) begin
      d = 8'($urandom);
      ans_q.push_back(8'hAA);
      wa_q.push_back(1200 + i);
      wd_q.push_back(d);
      send_byte(d, 12);
    end
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst_mid");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Fresh packet after reset decodes from the start.
    send_pkt(8'h00, 8'h00, 8'hDD);
    repeat (30) @(negedge clk);

    chk("ans_q_left", 32'(ans_q.size()), 32'd0);
    chk("wr_q_left",  32'(wa_q.size()),  32'd0);
    chk("row_q_left", 32'(row_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_row_parser.md
# uart_row_parser

Packet parser between `uart_receiver` and the VGA frame buffer inside `uart2vga_with_answer`. It consumes received UART bytes and decodes row packets of the form {Y low, Y high, 240 pixel bytes, stop byte}. It issues byte writes into the frame buffer and queues a one-byte answer to `uart_transmiter` for every received byte.

## Interface
Parameters:
- `BYTE_SIZE_ROW`, 240, pixel bytes per row (640 px × 3 bit).
- `HEIGHT`, 480, number of valid rows.
- `STOP_BYTE`, 8'hDD, required packet terminator.
- `ANSWER_CODE_TAKE_ROW`, 8'hCC, answer to each Y byte.
- `ANSWER_CODE`, 8'hAA, answer to each pixel byte.
- `SUCCESSFULLY_RECEIVED`, 8'hFF, answer to a valid stop byte.
- `NOT_ALL_RECEIVED`, 8'h11, answer to a bad stop byte, a bad row, or a timeout.
- `TIMEOUT_CYCLES`, 500_000, maximum inter-byte gap in clk cycles.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `rx_data`  in  8  received byte; valid when `rx_done` is high.
- `rx_done`  in  1  one-cycle strobe from `uart_receiver`.
- `tx_busy`  in  1  `uart_transmiter` busy.
- `tx_start`  out  1  one-cycle start strobe to the transmitter.
- `tx_data`  out  8  answer byte; held stable from the `tx_start` cycle until the next `tx_start`.
- `fb_we`  out  1  frame-buffer byte write strobe.
- `fb_addr`  out  17  byte address, computed as y*240 + index.
- `fb_wdata`  out  8  pixel byte.
- `row_done`  out  1  one-cycle pulse when a packet completes successfully.
- `row_y`  out  9  row index of the last accepted Y; it is valid when `row_done` pulses.
- `ans_ovf`  out  1  sticky flag: an answer was dropped.

## Operation
- FSM states: `Y_LO`, `Y_HI`, `DATA`, `STOP`. The reset state is `Y_LO`.
- Every transition happens only on `rx_done`; there is one exception, the timeout described in Configuration.
- `Y_LO` state:
  - The byte is latched as `y[7:0]`.
  - Queue answer 0xCC; next state `Y_HI`.
- `Y_HI` state:
  - `y[8] = rx_data[0]`; `rx_data[7:1]` are ignored.
  - Set `row_bad = (y >= HEIGHT)`.
  - Compute `base = (y<<8) - (y<<4)`, which equals y*240.
  - Clear `idx`.
  - Queue 0xCC; next state `DATA`.
- `DATA` state:
  - If `row_bad` is clear, write `fb_addr = base + idx` and `fb_wdata = rx_data`. If `row_bad` is set, the write is suppressed.
  - Queue 0xAA; increment `idx`.
  - When `idx == BYTE_SIZE_ROW-1`, go to `STOP`.
- `STOP` state:
  - If `rx_data == STOP_BYTE` and `row_bad` is clear: queue 0xFF and pulse `row_done`.
  - Otherwise: queue 0x11.
  - Always return to `Y_LO`.
- Answer path:
  - One pending register holds the queued answer.
  - It is launched as `tx_start` when it is pending, `tx_busy` is 0, and no `tx_start` was issued in the previous cycle. The blocked cycle after a start covers the transmitter's busy-rise latency.
  - If an answer is queued while one is already pending, the new answer replaces the pending one and `ans_ovf` is set. `ans_ovf` is cleared only by reset.
- No arithmetic wraps: the maximum address is 479*240 + 239 = 115199, which is below 2^17.

## Timing
- `rx_done` in cycle t produces `fb_we`, `fb_addr` and `fb_wdata` in cycle t+1.
  - `fb_we` is a single-cycle pulse.
  - Address and data hold their values until the next write.
- `row_done` pulses in cycle t+1 of the stop byte.
- Earliest answer: `tx_start` in t+1 if the pending register was empty and `tx_busy` was 0 in cycle t.
- If `rx_done` coincides with the cycle where the pending answer launches, the launch uses the old pending value. The new answer then becomes pending without setting an overflow.
- Reset values while `rst_n` is low, all applied asynchronously:
  - state = `Y_LO`, `idx` = 0, pending empty.
  - `tx_start` = 0, `tx_data` = 8'h00.
  - `fb_we` = 0, `fb_addr` = 0, `fb_wdata` = 0.
  - `row_done` = 0, `row_y` = 0, `ans_ovf` = 0.
- Reset in the middle of a packet drops the partial row and the pending answer. Bytes already written to the frame buffer remain there.

## Configuration
- `PARSER_TIMEOUT_EN` defined:
  - A gap counter runs in every state except `Y_LO` and restarts on each `rx_done`.
  - When it reaches `TIMEOUT_CYCLES`, the block queues 0x11, returns to `Y_LO` and clears `idx`. No `row_done` is issued.
- `PARSER_TIMEOUT_EN` undefined:
  - No counter is present; the parser waits indefinitely for the next byte.
  - The `TIMEOUT_CYCLES` parameter is ignored.

## Test plan
- Full packet, Y bytes 0x10 then 0x22, 240 random bytes, then 0xDD.
  - Expect answers 0xCC, 0xCC, then 240 × 0xAA, then 0xFF.
  - Expect 240 writes at addresses 3840..4079 carrying the sent bytes in order.
  - Expect `row_done` with `row_y` = 16.
- Same packet but the final byte is 0x00 → final answer 0x11; no `row_done`; the 240 writes still occur.
- Y = 0x01E0 (row 480) → no `fb_we` for the whole packet; answers 0xCC, 0xCC, 240 × 0xAA, then 0x11.
- With `PARSER_TIMEOUT_EN` defined and `TIMEOUT_CYCLES` = 1000: send Y plus 10 data bytes, then stay idle.
  - Expect 0x11 about 1000 cycles after the last byte.
  - A following full packet for row 0 then succeeds with answer 0xFF and writes at addresses 0..239.
- Hold `tx_busy` = 1 across three `rx_done` strobes → `ans_ovf` = 1. After `tx_busy` is released, exactly one `tx_start` is issued, carrying the last queued code.
- Assert `rst_n` low after 100 data bytes → all outputs go to their reset values immediately. The next packet is decoded from `Y_LO` and ends with answer 0xFF.
